audio_playback_ctrl: RTL and testbench
======================================

Name: audio_playback_ctrl

Overview:
Playback sequencer that sits between the recorder SRAM and the I2S DAC serializer. Once per left-channel frame it fetches one or two 16-bit samples from SRAM. It applies speed control: fast skip, slow hold or slow linear interpolation. It then hands the resulting word to the serializer with a one-cycle enable. It also handles start, pause, stop and end-of-recording.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 16, sample width; signed two's complement

Ports:
i_clk  in  1  BCLK-domain clock, shared with the serializer
i_rst  in  1  synchronous active-high reset
i_start  in  1  pulse; begin from address 0, or resume from pause
i_pause  in  1  pulse; freeze at the current address
i_stop  in  1  pulse; abort and return to IDLE
i_mode  in  2  00 normal/fast, 01 slow-hold, 10 slow-linear, 11 treated as 00
i_speed  in  3  speed factor F = i_speed+1 (1..8)
i_end_addr  in  ADDR_W  last valid sample address (inclusive)
i_daclrck  in  1  DAC LR clock
i_sram_data  in  DATA_W  SRAM read data; valid the cycle after the address is driven
o_sram_addr  out  ADDR_W  SRAM read address
o_dac_data  out  DATA_W  sample to the serializer
o_dac_en  out  1  one-cycle strobe: o_dac_data is valid, serializer starts
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse when playback passes i_end_addr

Behaviour:
- Reset:
  - all outputs 0; state IDLE; addr 0; sub-counter k 0; lrck_q 0.
- Frame tick:
  - lrck_q <= i_daclrck every cycle.
  - tick = lrck_q & ~i_daclrck, i.e. the falling edge (left channel).
  - Ticks outside WAIT are ignored.
- States and transitions:
  - IDLE -> WAIT on i_start; addr=0, k=0.
  - WAIT -> FETCH0 on tick. F and mode are latched here, so speed or mode changes apply at frame boundaries only.
  - FETCH0 drives o_sram_addr=addr for 1 cycle; s0 is captured from i_sram_data in the next state.
  - FETCH1 (slow-linear only) drives addr+1; s1 is captured. If addr==i_end_addr, no read is issued and s1=s0.
  - CALC (1 cycle) computes the output.
  - OUT (1 cycle): o_dac_data updated, o_dac_en=1; advance addr/k; then back to WAIT.
- Latency:
  - tick to o_dac_en is 4 cycles (normal/hold) or 5 cycles (linear), counted from the tick cycle.
- Output values:
  - normal and slow-hold: out = s0.
  - slow-linear: out = s0 + ((s1-s0)*k)/F.
  - The difference is 17-bit signed and the product 20-bit signed.
  - Division truncates toward zero; the result always fits DATA_W.
- Advance at OUT:
  - normal: addr += F.
  - slow modes: if k==F-1 then k=0 and addr+=1; else k+=1.
  - If F shrinks so that the latched k >= F, then k=0 and addr+=1 at that OUT.
- End of recording:
  - If the advanced addr > i_end_addr (compare at ADDR_W+1 bits, no wrap), pulse o_done in the following cycle and go to IDLE.
  - In IDLE, addr=0.
  - The last in-range sample is always emitted.
- Pause:
  - i_pause in any busy state -> PAUSED after completing the current OUT if in FETCH/CALC (a sample in flight is finished).
  - In PAUSED: o_dac_en=0, addr and k held.
  - i_start in PAUSED -> WAIT.
- Stop:
  - i_stop in any state -> IDLE next cycle; addr=0, k=0, o_dac_en=0, no o_done.
  - o_dac_data is held at its last value.
- Priority on simultaneous pulses: stop > pause > start.
- i_start while already in WAIT/FETCH/CALC/OUT: ignored.
- o_dac_en is never asserted twice within one frame.
- i_rst mid-operation forces the reset values above on the next edge, regardless of state.

Test Plan:
- Normal playback:
  - Stimulus: SRAM[0..3]=100,200,300,400; end=3; mode 00; speed 0; start.
  - Required: o_dac_en on 4 consecutive frames with data 100,200,300,400; then o_done once; o_busy falls.
- Fast mode:
  - Stimulus: speed=2 (F=3); end=7; SRAM[n]=n.
  - Required: outputs 0,3,6; then o_done; tick-to-en latency 4 cycles.
- Slow-hold:
  - Stimulus: F=2 (speed=1); SRAM 10,20; end=1.
  - Required: outputs 10,10,20,20; then done.
- Slow-linear:
  - Stimulus: F=4; SRAM 0,-100; end=1.
  - Required: outputs 0,-25,-50,-75, then -100 four times (end clamp s1=s0); latency 5 cycles.
- Pause/resume and stop:
  - Stimulus: pause after the 2nd output; hold 3 frames; start; later stop.
  - Required: no o_dac_en while paused; resume at the 3rd sample. After stop, o_busy=0 and addr=0 next cycle, with no o_done.
- Simultaneous and reset:
  - Stimulus: start+stop in the same cycle from IDLE; separately, i_rst asserted during FETCH1.
  - Required: stop+start leaves the block in IDLE. i_rst gives all outputs 0 on the next edge, and a following start replays from address 0.

Source files
------------

// File: rtl/audio_playback_ctrl.sv
// Playback sequencer between the recorder SRAM and the I2S DAC serializer.
// One sample per left-channel frame, with fast skip, slow hold or slow linear interpolation.
module audio_playback_ctrl #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_pause,
  input  logic                     i_stop,
  input  logic [1:0]               i_mode,
  input  logic [2:0]               i_speed,
  input  logic [ADDR_W-1:0]        i_end_addr,
  input  logic                     i_daclrck,
  input  logic signed [DATA_W-1:0] i_sram_data,
  output logic [ADDR_W-1:0]        o_sram_addr,
  output logic signed [DATA_W-1:0] o_dac_data,
  output logic                     o_dac_en,
  output logic                     o_busy,
  output logic                     o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_FETCH0, S_FETCH1, S_CALC, S_OUT, S_PAUSED
  } state_t;

  state_t                   r_state;
  logic                     r_lrck_q;
  logic [ADDR_W-1:0]        r_addr;
  logic [2:0]               r_k;
  logic [3:0]               r_f;
  logic                     r_fast;
  logic                     r_lin;
  logic                     r_pause_pend;
  logic signed [DATA_W-1:0] r_s0;
  logic signed [DATA_W-1:0] r_s1;

  logic                     w_tick;
  logic [ADDR_W:0]          w_addr_inc;
  logic [ADDR_W:0]          w_addr_fast;
  logic [ADDR_W:0]          w_addr_next;
  logic                     w_k_wrap;
  logic                     w_past_end;
  logic                     w_at_end;
  logic signed [DATA_W-1:0] w_interp;

  // s0 + ((s1-s0)*k)/F; signed division truncates toward zero
  function automatic logic signed [DATA_W-1:0] interp(
    input logic signed [DATA_W-1:0] s0,
    input logic signed [DATA_W-1:0] s1,
    input logic [2:0]               k,
    input logic [3:0]               f
  );
    logic signed [DATA_W:0]   diff;
    logic signed [DATA_W+3:0] d_x, k_x, f_x, s0_x, prod, quo, sum;
    diff = {s1[DATA_W-1], s1} - {s0[DATA_W-1], s0};
    d_x  = {{3{diff[DATA_W]}}, diff};
    k_x  = {{(DATA_W+1){1'b0}}, k};
    f_x  = {{DATA_W{1'b0}}, f};
    s0_x = {{4{s0[DATA_W-1]}}, s0};
    prod = d_x * k_x;
    quo  = prod / f_x;
    sum  = s0_x + quo;
    return sum[DATA_W-1:0];
  endfunction

  assign w_tick      = r_lrck_q & ~i_daclrck;
  assign w_addr_inc  = {1'b0, r_addr} + {{ADDR_W{1'b0}}, 1'b1};
  assign w_addr_fast = {1'b0, r_addr} + {{(ADDR_W-3){1'b0}}, r_f};
  // also catches a k left over from a larger F
  assign w_k_wrap    = ({1'b0, r_k} + 4'd1) >= r_f;
  assign w_at_end    = (r_addr == i_end_addr);
  assign w_interp    = interp(r_s0, r_s1, r_k, r_f);

  always_comb begin
    w_addr_next = {1'b0, r_addr};
    if (r_fast)        w_addr_next = w_addr_fast;
    else if (w_k_wrap) w_addr_next = w_addr_inc;
  end

  assign w_past_end = w_addr_next > {1'b0, i_end_addr};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_lrck_q     <= 1'b0;
      r_addr       <= '0;
      r_k          <= '0;
      r_f          <= 4'd1;
      r_fast       <= 1'b1;
      r_lin        <= 1'b0;
      r_pause_pend <= 1'b0;
      r_s0         <= '0;
      r_s1         <= '0;
      o_sram_addr  <= '0;
      o_dac_data   <= '0;
      o_dac_en     <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      r_lrck_q <= i_daclrck;
      o_dac_en <= 1'b0;
      o_done   <= 1'b0;
      if (i_stop) begin
        r_state      <= S_IDLE;
        r_addr       <= '0;
        r_k          <= '0;
        r_pause_pend <= 1'b0;
        o_busy       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state <= S_WAIT;
              r_addr  <= '0;
              r_k     <= '0;
              o_busy  <= 1'b1;
            end
          end
          S_WAIT: begin
            if (i_pause) begin
              r_state <= S_PAUSED;
            end else if (w_tick) begin
              r_state     <= S_FETCH0;
              r_f         <= {1'b0, i_speed} + 4'd1;
              r_fast      <= (i_mode != 2'b01) && (i_mode != 2'b10);
              r_lin       <= (i_mode == 2'b10);
              o_sram_addr <= r_addr;
            end
          end
          S_FETCH0: begin
            if (i_pause) r_pause_pend <= 1'b1;
            if (r_lin) begin
              r_state <= S_FETCH1;
              if (!w_at_end) o_sram_addr <= w_addr_inc[ADDR_W-1:0];
            end else begin
              r_state <= S_CALC;
            end
          end
          S_FETCH1: begin
            if (i_pause) r_pause_pend <= 1'b1;
            r_s0    <= i_sram_data;
            r_state <= S_CALC;
          end
          S_CALC: begin
            if (i_pause) r_pause_pend <= 1'b1;
            if (r_lin) r_s1 <= w_at_end ? r_s0 : i_sram_data;
            else       r_s0 <= i_sram_data;
            r_state <= S_OUT;
          end
          S_OUT: begin
            o_dac_data   <= r_lin ? w_interp : r_s0;
            o_dac_en     <= 1'b1;
            r_pause_pend <= 1'b0;
            if (w_past_end) begin
              r_state <= S_IDLE;
              r_addr  <= '0;
              r_k     <= '0;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
            end else begin
              r_addr  <= w_addr_next[ADDR_W-1:0];
              if (!r_fast) r_k <= w_k_wrap ? 3'd0 : r_k + 3'd1;
              r_state <= (r_pause_pend || i_pause) ? S_PAUSED : S_WAIT;
            end
          end
          S_PAUSED: begin
            if (!i_pause && i_start) r_state <= S_WAIT;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_playback_ctrl.sv
// Bench for audio_playback_ctrl: directed and random playback against a list-building reference model.
module tb_audio_playback_ctrl;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst = 1'b1, start = 1'b0, pause = 1'b0, stop = 1'b0, lrck = 1'b0;
  logic [1:0]               mode = 2'b00;
  logic [2:0]               speed = 3'd0;
  logic [ADDR_W-1:0]        end_addr = '0;
  logic signed [DATA_W-1:0] sram_data = '0;
  logic [ADDR_W-1:0]        sram_addr;
  logic signed [DATA_W-1:0] dac_data;
  logic                     dac_en, busy, done;

  audio_playback_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_mode(mode), .i_speed(speed), .i_end_addr(end_addr), .i_daclrck(lrck),
    .i_sram_data(sram_data), .o_sram_addr(sram_addr), .o_dac_data(dac_data),
    .o_dac_en(dac_en), .o_busy(busy), .o_done(done)
  );

  logic signed [15:0] mem [256];
  int checks = 0, errors = 0;
  int exp_q[$], got_q[$], lat_q[$];
  int done_cnt = 0, multi_en = 0, en_frame = 0, cyc = 0, tick_cyc = 0, tick_cnt = 0;
  logic lrck_prev = 1'b0;

  always @(posedge clk) sram_data <= (sram_addr < 256) ? mem[sram_addr[7:0]] : '0;

  // 32-cycle frames, LR clock changes on the falling clock edge
  initial forever begin
    repeat (16) @(negedge clk);
    lrck = ~lrck;
  end

  always @(posedge clk) begin
    cyc++;
    if (lrck_prev && !lrck) begin
      tick_cyc = cyc;
      tick_cnt++;
      en_frame = 0;
    end
    lrck_prev = lrck;
  end

  always @(negedge clk) begin
    if (dac_en) begin
      got_q.push_back(int'(dac_data));
      lat_q.push_back(cyc - tick_cyc + 1);
      en_frame++;
      if (en_frame > 1) multi_en++;
    end
    if (done) done_cnt++;
  end

  // Reference: list of samples the speed rules produce for SRAM[0..last]
  task automatic build_expected(input int m, input int f, input int last);
    int s0, s1;
    exp_q.delete();
    if (m == 1) begin
      for (int a = 0; a <= last; a++)
        for (int r = 0; r < f; r++) exp_q.push_back(int'(mem[a]));
    end else if (m == 2) begin
      for (int a = 0; a <= last; a++) begin
        s0 = int'(mem[a]);
        s1 = (a == last) ? s0 : int'(mem[a+1]);
        for (int k = 0; k < f; k++) exp_q.push_back(s0 + ((s1 - s0) * k) / f);
      end
    end else begin
      for (int a = 0; a <= last; a += f) exp_q.push_back(int'(mem[a]));
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    lat_q.delete();
    done_cnt = 0;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (got_q.size() >= n) begin to = 1'b0; break; end
    end
  endtask

  task automatic wait_done(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt > 0) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++; if (sram_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", sram_addr); end
    checks++; if (dac_data !== '0) begin errors++; $display("FAIL reset_data: got %0d expected 0", dac_data); end
    checks++; if (dac_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", dac_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0;
  endtask

  task automatic test_playback(input string name, input int m, input int sp, input int last);
    bit to;
    int n, lat_exp;
    mode = 2'(m); speed = 3'(sp); end_addr = ADDR_W'(last);
    build_expected(m, sp + 1, last);
    clear_mon();
    do_start();
    wait_done((exp_q.size() + 3) * 32 + 64, to);
    checks++; if (to) begin errors++; $display("FAIL %s_timeout: got no done, expected done", name); end
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s_count: got %0d samples expected %0d", name, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    lat_exp = (m == 2) ? 5 : 4;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_q[i] != exp_q[i]) begin
        errors++; $display("FAIL %s_data[%0d]: got %0d expected %0d", name, i, got_q[i], exp_q[i]);
      end
      checks++;
      if (lat_q[i] != lat_exp) begin
        errors++; $display("FAIL %s_latency[%0d]: got %0d expected %0d", name, i, lat_q[i], lat_exp);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done_pulses: got %0d expected 1", name, done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after: got %b expected 0", name, busy); end
  endtask

  task automatic test_normal();
    mem[0] = 100; mem[1] = 200; mem[2] = 300; mem[3] = 400;
    test_playback("normal", 0, 0, 3);
  endtask

  task automatic test_fast();
    for (int i = 0; i < 16; i++) mem[i] = 16'(i);
    test_playback("fast", 0, 2, 7);
  endtask

  task automatic test_hold();
    mem[0] = 10; mem[1] = 20;
    test_playback("hold", 1, 1, 1);
  endtask

  task automatic test_linear();
    mem[0] = 0; mem[1] = -100;
    test_playback("linear", 2, 3, 1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      test_playback("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 9)));
    end
  endtask

  task automatic test_pause_resume();
    bit to;
    for (int i = 0; i < 8; i++) mem[i] = 16'(1000 + 7 * i);
    mode = 2'b00; speed = 3'd0; end_addr = 20'd5;
    build_expected(0, 1, 5);
    clear_mon();
    do_start();
    wait_got(2, 200, to);
    checks++; if (to) begin errors++; $display("FAIL pause_reach2: got %0d samples expected 2", got_q.size()); end
    @(negedge clk); pause = 1'b1;
    @(negedge clk); pause = 1'b0;
    repeat (96) @(negedge clk);
    #1;
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL pause_no_en: got %0d samples expected 2", got_q.size()); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pause_busy: got %b expected 1", busy); end
    do_start();
    wait_done(400, to);
    checks++; if (to) begin errors++; $display("FAIL resume_timeout: got no done, expected done"); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL resume_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL resume_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stop();
    bit to;
    int last;
    for (int i = 0; i < 8; i++) mem[i] = 16'(-3000 + 11 * i);
    mode = 2'b00; speed = 3'd0; end_addr = 20'd5;
    build_expected(0, 1, 5);
    clear_mon();
    do_start();
    wait_got(2, 200, to);
    checks++; if (to) begin errors++; $display("FAIL stop_reach2: got %0d samples expected 2", got_q.size()); end
    last = got_q[$];
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b expected 0", busy); end
    repeat (96) @(negedge clk);
    #1;
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL stop_no_en: got %0d samples expected 2", got_q.size()); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL stop_no_done: got %0d expected 0", done_cnt); end
    checks++; if (int'(dac_data) != last) begin errors++; $display("FAIL stop_data_hold: got %0d expected %0d", dac_data, last); end
    test_playback("after_stop", 0, 0, 5);
  endtask

  task automatic test_simultaneous();
    clear_mon();
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL startstop_busy: got %b expected 0", busy); end
    repeat (96) @(negedge clk);
    #1;
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL startstop_no_en: got %0d samples expected 0", got_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int t0;
    for (int i = 0; i < 8; i++) mem[i] = 16'(500 - 150 * i);
    mode = 2'b10; speed = 3'd3; end_addr = 20'd3;
    clear_mon();
    do_start();
    wait_got(1, 200, to);
    checks++; if (to) begin errors++; $display("FAIL rstmid_reach1: got %0d samples expected 1", got_q.size()); end
    t0 = tick_cnt;
    for (int i = 0; i < 100 && tick_cnt == t0; i++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (sram_addr !== '0) begin errors++; $display("FAIL rstmid_addr: got %0h expected 0", sram_addr); end
    checks++; if (dac_data !== '0) begin errors++; $display("FAIL rstmid_data: got %0d expected 0", dac_data); end
    checks++; if (dac_en !== 1'b0) begin errors++; $display("FAIL rstmid_en: got %b expected 0", dac_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done); end
    rst = 1'b0;
    test_playback("after_rst", 2, 3, 3);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_normal();
    test_fast();
    test_hold();
    test_linear();
    test_random();
    test_pause_resume();
    test_stop();
    test_simultaneous();
    test_reset_mid();
    checks++;
    if (multi_en != 0) begin errors++; $display("FAIL one_en_per_frame: got %0d extra strobes expected 0", multi_en); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
